// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM state encoding,
// channel assignments and a width helper used by the top and the ID FIFO.
package mem_port_arbiter_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        HOLD = 1'b1
    } mem_arb_state_e;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int MEM_ARB_CH_FETCH = 0;
    localparam int MEM_ARB_CH_LSU   = 1;

    // Index width for n entries, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// In-order FIFO of channel IDs for accepted requests; the head names the
// channel that owns the next DRAM response.
module mem_arb_id_fifo
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    assign do_push = push && (!full || do_pop);
    assign rdata   = slots[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            slots[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-channel arbiter onto the single DRAM request port with in-order response
// routing. Define MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          ch_req_ip,
    input  logic [NUM_CH-1:0]          ch_we_ip,
    input  logic [NUM_CH*ADDR_W-1:0]   ch_addr_ip,
    input  logic [NUM_CH*DATA_W-1:0]   ch_wdata_ip,
    output logic [NUM_CH-1:0]          ch_gnt_op,
    output logic [NUM_CH-1:0]          ch_rvalid_op,
    output logic [DATA_W-1:0]          ch_rdata_op,
    output logic                       mem_req_op,
    output logic                       mem_we_op,
    output logic [ADDR_W-1:0]          mem_addr_op,
    output logic [DATA_W-1:0]          mem_wdata_op,
    input  logic                       mem_gnt_ip,
    input  logic                       mem_rvalid_ip,
    input  logic [DATA_W-1:0]          mem_rdata_ip,
    output logic [$clog2(MAX_OUTST):0] outst_cnt_op,
    output logic                       err_op
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [0:0]       state;
    logic [IDX_W-1:0] hold_idx;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] head;
    logic             any_req;
    logic             full;
    logic             empty;
    logic             accept;
    logic             pop;

`ifdef MEM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_req_ip[i]) begin
                winner = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr;
    logic             rr_found;
    int               rr_idx;

    // Scan upward from the pointer with wrap; the first requester wins.
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            rr_idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!rr_found && ch_req_ip[rr_idx]) begin
                rr_found = 1'b1;
                winner   = IDX_W'(rr_idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (int'(sel) == NUM_CH - 1) ? '0 : sel + 1'b1;
        end
    end
`endif

    assign any_req = |ch_req_ip;
    // HOLD is only entered with a free slot, so it is never blocked by full.
    assign sel          = (state == ST_HOLD) ? hold_idx : winner;
    assign mem_req_op   = (state == ST_HOLD) || (any_req && !full);
    assign mem_we_op    = mem_req_op && ch_we_ip[sel];
    assign mem_addr_op  = mem_req_op ? ch_addr_ip[int'(sel)*ADDR_W +: ADDR_W] : '0;
    assign mem_wdata_op = mem_req_op ? ch_wdata_ip[int'(sel)*DATA_W +: DATA_W] : '0;
    assign accept       = mem_req_op && mem_gnt_ip;
    assign pop          = mem_rvalid_ip && !empty;
    assign ch_rdata_op  = pop ? mem_rdata_ip : '0;

    always_comb begin
        ch_gnt_op = '0;
        if (accept) begin
            ch_gnt_op[sel] = 1'b1;
        end
    end

    always_comb begin
        ch_rvalid_op = '0;
        if (pop) begin
            ch_rvalid_op[head] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_ARB;
            hold_idx <= '0;
        end else begin
            case (state)
                ST_ARB: begin
                    if (mem_req_op && !mem_gnt_ip) begin
                        state    <= ST_HOLD;
                        hold_idx <= winner;
                    end
                end
                ST_HOLD: begin
                    if (mem_gnt_ip) begin
                        state <= ST_ARB;
                    end
                end
                default: state <= ST_ARB;
            endcase
        end
    end

    // A response with nothing outstanding is a protocol violation; keep it until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_op <= 1'b0;
        end else if (mem_rvalid_ip && empty) begin
            err_op <= 1'b1;
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clock (clock),
        .reset (reset),
        .push  (accept),
        .pop   (mem_rvalid_ip),
        .wdata (sel),
        .rdata (head),
        .count (outst_cnt_op),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (NUM_CH=2, MAX_OUTST=2). Expectations
// follow MEM_ARB_FIXED_PRIO_EN when that macro is defined.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic [1:0]  ch_req;
    logic [1:0]  ch_we;
    logic [63:0] ch_addr;
    logic [63:0] ch_wdata;
    logic [1:0]  ch_gnt;
    logic [1:0]  ch_rvalid;
    logic [31:0] ch_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [1:0]  outst_cnt;
    logic        err;

    int n_compared;
    int n_mismatched;

    mem_port_arbiter #(
        .NUM_CH    (2),
        .ADDR_W    (32),
        .DATA_W    (32),
        .MAX_OUTST (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .ch_req_ip     (ch_req),
        .ch_we_ip      (ch_we),
        .ch_addr_ip    (ch_addr),
        .ch_wdata_ip   (ch_wdata),
        .ch_gnt_op     (ch_gnt),
        .ch_rvalid_op  (ch_rvalid),
        .ch_rdata_op   (ch_rdata),
        .mem_req_op    (mem_req),
        .mem_we_op     (mem_we),
        .mem_addr_op   (mem_addr),
        .mem_wdata_op  (mem_wdata),
        .mem_gnt_ip    (mem_gnt),
        .mem_rvalid_ip (mem_rvalid),
        .mem_rdata_ip  (mem_rdata),
        .outst_cnt_op  (outst_cnt),
        .err_op        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Per-address DRAM read model.
    function automatic logic [31:0] model(input logic [31:0] addr);
        return (addr * 32'd3) ^ 32'h5A5A_0000;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs just after a rising edge, then let combinational outputs settle.
    task automatic applyStimulus(input logic [1:0] req, input logic gnt, input logic rv, input logic [31:0] rd);
        @(posedge clock);
        #1;
        ch_req     = req;
        mem_gnt    = gnt;
        mem_rvalid = rv;
        mem_rdata  = rd;
        #1;
    endtask

    task automatic pulseReset();
        @(posedge clock);
        #1;
        reset      = 1'b1;
        ch_req     = 2'b00;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [31:0] addr0;
        logic [31:0] addr1;
        int          exp_win;
        int          prev_win;
        logic [31:0] prev_addr;

        n_compared   = 0;
        n_mismatched = 0;
        addr0        = 32'h0000_0100;
        addr1        = 32'h0000_0200;
        reset        = 1'b1;
        ch_req       = 2'b00;
        ch_we        = 2'b10;
        ch_addr      = {addr1, addr0};
        ch_wdata     = {32'hCAFE_0001, 32'hCAFE_0000};
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
        mem_rdata    = '0;

        repeat (2) @(posedge clock);
        #2;
        checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
        checkOutput("rst_gnt", 64'(ch_gnt), 64'd0);
        checkOutput("rst_rvalid", 64'(ch_rvalid), 64'd0);
        checkOutput("rst_cnt", 64'(outst_cnt), 64'd0);
        checkOutput("rst_err", 64'(err), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Both channels request every cycle, responses one cycle behind.
        prev_win  = 0;
        prev_addr = '0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus((k < 4) ? 2'b11 : 2'b00, 1'b1, k > 0, (k > 0) ? model(prev_addr) : 32'd0);
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_win = 0;
`else
            exp_win = k % 2;
`endif
            checkOutput("rr_cnt", 64'(outst_cnt), (k == 0) ? 64'd0 : 64'd1);
            if (k < 4) begin
                checkOutput("rr_gnt", 64'(ch_gnt), 64'(1 << exp_win));
                checkOutput("rr_addr", 64'(mem_addr), (exp_win == 1) ? 64'(addr1) : 64'(addr0));
                checkOutput("rr_we", 64'(mem_we), 64'(exp_win));
                checkOutput("rr_wdata", 64'(mem_wdata), (exp_win == 1) ? 64'h CAFE_0001 : 64'h CAFE_0000);
            end
            if (k > 0) begin
                checkOutput("rr_rvalid", 64'(ch_rvalid), 64'(1 << prev_win));
                checkOutput("rr_rdata", 64'(ch_rdata), 64'(model(prev_addr)));
            end
            prev_win  = exp_win;
            prev_addr = (exp_win == 1) ? addr1 : addr0;
        end

        // Channel 1 requests 0x80 without grant; channel 0 joins a cycle later.
        addr1   = 32'h0000_0080;
        ch_addr = {addr1, addr0};
        applyStimulus(2'b10, 1'b0, 1'b0, '0);
        checkOutput("hold_cnt0", 64'(outst_cnt), 64'd0);
        checkOutput("hold_req", 64'(mem_req), 64'd1);
        checkOutput("hold_addr_a", 64'(mem_addr), 64'h80);
        checkOutput("hold_gnt_a", 64'(ch_gnt), 64'd0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        checkOutput("hold_addr_b", 64'(mem_addr), 64'h80);
        checkOutput("hold_gnt_b", 64'(ch_gnt), 64'd0);
        applyStimulus(2'b11, 1'b0, 1'b0, '0);
        checkOutput("hold_addr_c", 64'(mem_addr), 64'h80);
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        checkOutput("hold_addr_d", 64'(mem_addr), 64'h80);
        checkOutput("hold_gnt_d", 64'(ch_gnt), 64'b10);
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        checkOutput("hold_next_gnt", 64'(ch_gnt), 64'b01);
        checkOutput("hold_next_addr", 64'(mem_addr), 64'(addr0));

        // Two requests outstanding: the port must stop requesting.
        applyStimulus(2'b01, 1'b1, 1'b0, '0);
        checkOutput("full_cnt", 64'(outst_cnt), 64'd2);
        checkOutput("full_req", 64'(mem_req), 64'd0);
        checkOutput("full_gnt", 64'(ch_gnt), 64'd0);
        applyStimulus(2'b01, 1'b1, 1'b1, model(32'h80));
        checkOutput("full_pop_req", 64'(mem_req), 64'd0);
        checkOutput("full_pop_rvalid", 64'(ch_rvalid), 64'b10);
        checkOutput("full_pop_rdata", 64'(ch_rdata), 64'(model(32'h80)));
        applyStimulus(2'b01, 1'b1, 1'b1, model(addr0));
        checkOutput("pushpop_cnt_before", 64'(outst_cnt), 64'd1);
        checkOutput("pushpop_gnt", 64'(ch_gnt), 64'b01);
        checkOutput("pushpop_rvalid", 64'(ch_rvalid), 64'b01);
        applyStimulus(2'b00, 1'b0, 1'b1, model(addr0));
        checkOutput("pushpop_cnt_after", 64'(outst_cnt), 64'd1);
        checkOutput("drain_rvalid", 64'(ch_rvalid), 64'b01);

        // Response with nothing outstanding.
        applyStimulus(2'b00, 1'b0, 1'b1, 32'h1234_5678);
        checkOutput("spur_cnt", 64'(outst_cnt), 64'd0);
        checkOutput("spur_rvalid", 64'(ch_rvalid), 64'd0);
        checkOutput("spur_err_pre", 64'(err), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("spur_err_set", 64'(err), 64'd1);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("spur_err_sticky", 64'(err), 64'd1);
        pulseReset();
        checkOutput("spur_err_clr", 64'(err), 64'd0);

        // Reset with two requests in flight.
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        applyStimulus(2'b11, 1'b1, 1'b0, '0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("mid_cnt_pre", 64'(outst_cnt), 64'd2);
        pulseReset();
        checkOutput("mid_cnt_post", 64'(outst_cnt), 64'd0);
        checkOutput("mid_state_arb", 64'(mem_req), 64'd0);
        checkOutput("mid_err_post", 64'(err), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF);
        checkOutput("mid_late_rvalid", 64'(ch_rvalid), 64'd0);
        applyStimulus(2'b00, 1'b0, 1'b0, '0);
        checkOutput("mid_late_err", 64'(err), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule
